// File: rtl/sram_port_arbiter_if.sv
// Bundle between the two requesters, the arbiter and the shared 16x8 SRAM.
// slave = arbiter side, master = environment (requesters plus SRAM model).
interface sram_port_arbiter_if #(
  parameter int AW = 4,
  parameter int DW = 8
);
  // Handshake: reqN is held high with weN/addrN/wdataN stable until ackN pulses
  // for one cycle. rdataN is valid from that ack cycle and is held until the next read by N.
  logic          req0;
  logic          req1;
  logic          we0;
  logic          we1;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata0;
  logic [DW-1:0] wdata1;
  logic          gnt0;
  logic          gnt1;
  logic          ack0;
  logic          ack1;
  logic [DW-1:0] rdata0;
  logic [DW-1:0] rdata1;
  logic          mem_cs;
  logic          mem_rd;
  logic          mem_wr;
  logic          mem_oe;
  logic [AW-1:0] mem_ar;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    output gnt0, gnt1, ack0, ack1, rdata0, rdata1,
           mem_cs, mem_rd, mem_wr, mem_oe, mem_ar, mem_wdata
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    input  gnt0, gnt1, ack0, ack1, rdata0, rdata1,
           mem_cs, mem_rd, mem_wr, mem_oe, mem_ar, mem_wdata
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter and access sequencer sharing one SRAM between two ports.
// Each access runs IDLE -> ADDR -> STROBE -> [WAIT x RD_WAIT, reads] -> DONE.
module sram_port_arbiter #(
  parameter int AW      = 4,
  parameter int DW      = 8,
  parameter int RD_WAIT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  sram_port_arbiter_if.slave   bus,
  output logic [2:0]           state_o,
  output logic                 prio_o
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ADDR   = 3'd1;
  localparam logic [2:0] S_STROBE = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam bit         NO_WAIT   = (RD_WAIT == 0);
  localparam logic [2:0] WAIT_LOAD = (RD_WAIT > 0) ? 3'(RD_WAIT - 1) : 3'd0;

  logic [2:0]    state_q, state_d;
  logic          owner_q, owner_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          prio_q, prio_d;
  logic [DW-1:0] rdata0_q, rdata0_d;
  logic [DW-1:0] rdata1_q, rdata1_d;
  logic          capture;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    prio_d   = prio_q;
    capture  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.req0 | bus.req1) begin
          // Port 1 wins when it is alone or when both ask and it holds priority.
          owner_d = bus.req1 & (~bus.req0 | prio_q);
          we_d    = owner_d ? bus.we1    : bus.we0;
          addr_d  = owner_d ? bus.addr1  : bus.addr0;
          wdata_d = owner_d ? bus.wdata1 : bus.wdata0;
          state_d = S_ADDR;
        end
      end
      S_ADDR: state_d = S_STROBE;
      S_STROBE: begin
        if (we_q) begin
          state_d = S_DONE;
        end else if (NO_WAIT) begin
          capture = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d   = WAIT_LOAD;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == 3'd0) begin
          capture = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_DONE: begin
        prio_d  = ~owner_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    if (capture) begin
      if (owner_q) rdata1_d = bus.mem_rdata;
      else         rdata0_d = bus.mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      owner_q  <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= 3'd0;
      prio_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      prio_q   <= prio_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  logic busy;
  logic in_access;
  logic drive_phase;

  assign busy        = (state_q != S_IDLE);
  assign in_access   = (state_q == S_ADDR) | (state_q == S_STROBE) | (state_q == S_WAIT);
  assign drive_phase = (state_q == S_ADDR) | (state_q == S_STROBE);

  assign bus.gnt0      = busy & ~owner_q;
  assign bus.gnt1      = busy & owner_q;
  assign bus.ack0      = (state_q == S_DONE) & ~owner_q;
  assign bus.ack1      = (state_q == S_DONE) & owner_q;
  assign bus.rdata0    = rdata0_q;
  assign bus.rdata1    = rdata1_q;
  assign bus.mem_cs    = in_access;
  assign bus.mem_ar    = in_access ? addr_q : '0;
  assign bus.mem_oe    = we_q & drive_phase;
  assign bus.mem_wdata = (we_q & drive_phase) ? wdata_q : '0;
  assign bus.mem_wr    = we_q & (state_q == S_STROBE);
  assign bus.mem_rd    = ~we_q & ((state_q == S_STROBE) | (state_q == S_WAIT));

  assign state_o = state_q;
  assign prio_o  = prio_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Randomized and directed bench for sram_port_arbiter against a transaction-level
// timing model with its own SRAM array; extra instances exercise RD_WAIT = 0 and 3.
module tb_sram_port_arbiter;
  localparam int AW      = 4;
  localparam int DW      = 8;
  localparam int RD_WAIT = 1;
  localparam int BUDGET  = 40;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sram_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();
  logic [2:0] dut_state;
  logic       dut_prio;

  sram_port_arbiter #(.AW(AW), .DW(DW), .RD_WAIT(RD_WAIT)) u_dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .state_o (dut_state),
    .prio_o  (dut_prio)
  );

  logic [DW-1:0] sram [2**AW];
  assign bus.mem_rdata = sram[bus.mem_ar];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // behavioural model and scoreboard
  bit            m_active, m_owner, m_we, m_prio;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  int            m_t, m_len;
  logic [DW-1:0] exp_rdata [2];
  logic [DW-1:0] exp_q [$];
  int            ack_cnt [2];
  int            ack_seq [$];
  int            wr_cycles, rd_cycles;
  bit            e_gnt0, e_gnt1, e_ack, e_cs, e_wr, e_rd, e_oe;
  logic [DW-1:0] sb_val;

  initial begin
    m_active = 0; m_prio = 0; m_owner = 0; m_we = 0; m_t = 0; m_len = 0;
    m_addr = '0; m_wdata = '0;
    exp_rdata[0] = '0; exp_rdata[1] = '0;
    ack_cnt[0] = 0; ack_cnt[1] = 0; wr_cycles = 0; rd_cycles = 0;
    for (int i = 0; i < 2**AW; i++) sram[i] = '0;
    repeat (2) @(posedge clk);
    forever begin
      @(negedge clk);
      // Cycle t of a transaction counts from the IDLE cycle that accepted it (t=0).
      e_gnt0 = m_active && !m_owner;
      e_gnt1 = m_active && m_owner;
      e_ack  = m_active && (m_t == m_len);
      e_cs   = m_active && (m_t < m_len);
      e_wr   = m_active && m_we && (m_t == 2);
      e_rd   = m_active && !m_we && (m_t >= 2) && (m_t <= 2 + RD_WAIT);
      e_oe   = m_active && m_we && (m_t <= 2);
      chk("gnt0", bus.gnt0, e_gnt0);
      chk("gnt1", bus.gnt1, e_gnt1);
      chk("ack0", bus.ack0, e_ack && !m_owner);
      chk("ack1", bus.ack1, e_ack && m_owner);
      chk("mem_cs", bus.mem_cs, e_cs);
      chk("mem_wr", bus.mem_wr, e_wr);
      chk("mem_rd", bus.mem_rd, e_rd);
      chk("mem_oe", bus.mem_oe, e_oe);
      if (e_cs) chk("mem_ar", bus.mem_ar, m_addr);
      if (e_oe) chk("mem_wdata", bus.mem_wdata, m_wdata);
      chk("rdata0", bus.rdata0, exp_rdata[0]);
      chk("rdata1", bus.rdata1, exp_rdata[1]);
      chk("inv_rd_and_wr", bus.mem_rd & bus.mem_wr, 0);
      chk("inv_two_gnt", bus.gnt0 & bus.gnt1, 0);
      chk("inv_two_ack", bus.ack0 & bus.ack1, 0);
      chk("inv_oe_in_read", bus.mem_oe & bus.mem_rd, 0);
      if (e_ack && !m_we) begin
        chk("sb_has_entry", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          sb_val = exp_q.pop_front();
          chk("sb_rdata", m_owner ? bus.rdata1 : bus.rdata0, sb_val);
        end
      end
      if (bus.ack0) begin ack_cnt[0]++; ack_seq.push_back(0); end
      if (bus.ack1) begin ack_cnt[1]++; ack_seq.push_back(1); end
      if (bus.mem_wr) wr_cycles++;
      if (bus.mem_rd) rd_cycles++;
      // advance the model to the next cycle
      if (e_wr) sram[m_addr] = m_wdata;
      if (rst) begin
        m_active = 0;
        m_prio   = 0;
        exp_rdata[0] = '0;
        exp_rdata[1] = '0;
        exp_q.delete();
      end else if (m_active) begin
        if (m_t == m_len) begin
          m_active = 0;
          m_prio   = !m_owner;
        end else begin
          if (!m_we && m_t == m_len - 1) begin
            exp_rdata[m_owner] = sram[m_addr];
            exp_q.push_back(sram[m_addr]);
          end
          m_t++;
        end
      end else if (bus.req0 || bus.req1) begin
        m_owner  = (bus.req0 && bus.req1) ? m_prio : bus.req1;
        m_we     = m_owner ? bus.we1    : bus.we0;
        m_addr   = m_owner ? bus.addr1  : bus.addr0;
        m_wdata  = m_owner ? bus.wdata1 : bus.wdata0;
        m_len    = m_we ? 3 : 3 + RD_WAIT;
        m_t      = 1;
        m_active = 1;
      end
    end
  end

  // alternate-latency builds, read-only against a fixed data pattern
  bit alt_go = 0;
  bit alt_done [2];
  for (genvar g = 0; g < 2; g++) begin : g_alt
    localparam int RW = (g == 0) ? 0 : 3;
    sram_port_arbiter_if #(.AW(AW), .DW(DW)) abus ();
    logic [2:0]    a_state;
    logic          a_prio;
    int            a_lat;
    logic [DW-1:0] a_rd;
    logic [AW-1:0] a_addr;
    sram_port_arbiter #(.AW(AW), .DW(DW), .RD_WAIT(RW)) u_alt (
      .clk     (clk),
      .rst     (rst),
      .bus     (abus),
      .state_o (a_state),
      .prio_o  (a_prio)
    );
    assign abus.mem_rdata = {4'hC, abus.mem_ar};
    initial begin
      alt_done[g] = 0;
      abus.req0 = 0; abus.req1 = 0; abus.we0 = 0; abus.we1 = 0;
      abus.addr0 = '0; abus.addr1 = '0; abus.wdata0 = '0; abus.wdata1 = '0;
      a_addr = AW'(3 * g + 2);
      a_rd = '0;
      wait (alt_go);
      @(posedge clk); #1;
      abus.req0 = 1; abus.addr0 = a_addr;
      a_lat = -1;
      for (int n = 0; n < BUDGET; n++) begin
        @(negedge clk);
        if (abus.ack0) begin a_lat = n; a_rd = abus.rdata0; break; end
      end
      @(posedge clk); #1;
      abus.req0 = 0;
      chk($sformatf("t5_lat_rw%0d", RW), a_lat, (g == 0) ? 3 : 6);
      chk($sformatf("t5_rdata_rw%0d", RW), a_rd, {4'hC, a_addr});
      alt_done[g] = 1;
    end
  end

  // driver tasks
  task automatic apply_reset();
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  task automatic do_txn(input bit port, input bit we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input bit keep,
                        output int lat, output logic [DW-1:0] rd);
    if (port == 0) begin
      bus.req0 = 1; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d;
    end else begin
      bus.req1 = 1; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d;
    end
    lat = -1;
    rd  = '0;
    for (int n = 0; n < BUDGET; n++) begin
      @(negedge clk);
      if ((port == 0 && bus.ack0) || (port == 1 && bus.ack1)) begin
        lat = n;
        rd  = port ? bus.rdata1 : bus.rdata0;
        break;
      end
    end
    chk($sformatf("ack_seen_port%0d", port), lat >= 0, 1);
    @(posedge clk); #1;
    if (!keep) begin
      if (port == 0) bus.req0 = 0;
      else           bus.req1 = 0;
    end
  endtask

  task automatic rand_port(input bit port, input int n);
    int            lat;
    logic [DW-1:0] rd;
    bit            keep;
    int            gap;
    keep = 0;
    for (int i = 0; i < n; i++) begin
      gap = keep ? 0 : int'($urandom_range(0, 3));
      if (gap > 0) begin
        repeat (gap) @(posedge clk);
        #1;
      end
      keep = (i < n - 1) && ($urandom_range(0, 1) == 1);
      do_txn(port, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 2**AW - 1)),
             DW'($urandom_range(0, 255)), keep, lat, rd);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not complete t=%0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  int            lat0, lat1;
  logic [DW-1:0] rd0, rd1;

  initial begin
    rst = 1;
    bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
    bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("reset_outputs", {bus.gnt0, bus.gnt1, bus.ack0, bus.ack1, bus.mem_cs,
                          bus.mem_rd, bus.mem_wr, bus.mem_oe}, 0);
    chk("reset_rdata", {bus.rdata0, bus.rdata1}, 0);
    chk("reset_prio", dut_prio, 0);
    @(posedge clk); #1;

    // port 0 write then read of the same word
    wr_cycles = 0; rd_cycles = 0;
    do_txn(0, 1, 4'd3, 8'hA5, 0, lat0, rd0);
    chk("t1_write_latency", lat0, 3);
    do_txn(0, 0, 4'd3, 8'h00, 0, lat0, rd0);
    chk("t1_read_latency", lat0, 3 + RD_WAIT);
    chk("t1_read_data", rd0, 8'hA5);
    chk("t1_wr_cycles", wr_cycles, 1);
    chk("t1_rd_cycles", rd_cycles, 1 + RD_WAIT);

    // simultaneous requests right after reset
    apply_reset();
    fork
      do_txn(0, 1, 4'd1, 8'h11, 0, lat0, rd0);
      do_txn(1, 1, 4'd2, 8'h22, 0, lat1, rd1);
    join
    chk("t2_port0_latency", lat0, 3);
    chk("t2_port1_latency", lat1, 7);
    do_txn(0, 0, 4'd1, 8'h00, 0, lat0, rd0);
    chk("t2_readback0", rd0, 8'h11);
    do_txn(1, 0, 4'd2, 8'h00, 0, lat1, rd1);
    chk("t2_readback1", rd1, 8'h22);

    // continuous requests from both ports alternate
    apply_reset();
    ack_seq.delete();
    fork
      begin
        for (int i = 0; i < 3; i++) do_txn(0, 1, AW'(8 + i), DW'(8'h30 + i), i < 2, lat0, rd0);
      end
      begin
        for (int i = 0; i < 3; i++) do_txn(1, 1, AW'(12 + i), DW'(8'h40 + i), i < 2, lat1, rd1);
      end
    join
    chk("t3_ack_count", ack_seq.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < ack_seq.size()) chk($sformatf("t3_order_%0d", i), ack_seq[i], i % 2);
    end

    // reset during the strobe of a port 1 write
    apply_reset();
    ack_cnt[1] = 0;
    bus.req1 = 1; bus.we1 = 1; bus.addr1 = 4'd5; bus.wdata1 = 8'h5A;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0; bus.req1 = 0;
    @(negedge clk);
    chk("t4_gnt1_after_rst", bus.gnt1, 0);
    chk("t4_cs_after_rst", bus.mem_cs, 0);
    chk("t4_prio_after_rst", dut_prio, 0);
    repeat (5) @(negedge clk);
    chk("t4_no_ack1", ack_cnt[1], 0);
    @(posedge clk); #1;
    fork
      do_txn(0, 0, 4'd3, 8'h00, 0, lat0, rd0);
      do_txn(1, 0, 4'd5, 8'h00, 0, lat1, rd1);
    join
    chk("t4_port0_first", lat0, 3 + RD_WAIT);
    chk("t4_port1_second", lat1, 2 * (3 + RD_WAIT) + 1);

    // alternate RD_WAIT builds
    alt_go = 1;
    for (int n = 0; n < 100; n++) begin
      @(posedge clk);
      if (alt_done[0] && alt_done[1]) break;
    end
    chk("t5_alt_done", alt_done[0] && alt_done[1], 1);
    #1;

    // request withdrawn during ADDR still completes once
    ack_cnt[1] = 0;
    bus.req1 = 1; bus.we1 = 0; bus.addr1 = 4'd2;
    @(posedge clk); #1;
    bus.req1 = 0;
    repeat (8) @(negedge clk);
    chk("t6_single_ack1", ack_cnt[1], 1);
    chk("t6_idle_gnt1", bus.gnt1, 0);
    chk("t6_idle_cs", bus.mem_cs, 0);
    @(posedge clk); #1;

    // randomized traffic from both ports
    fork
      rand_port(0, 14);
      rand_port(1, 14);
    join
    repeat (4) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
